// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch vectors, PC step and
// the fetch FSM state encoding.
package cpu_pkg;

   localparam logic [31:0] PC_INIT_ADDR = 32'h0000_3000;
   localparam logic [31:0] PC_EXC_ADDR  = 32'h0000_4180;
   localparam int unsigned PC_STEP      = 4;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; overwrites the oldest
// entry when full.
module pc_ras #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] link_i,
   output logic [W-1:0] top_o,
   output logic         empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic [W-1:0]  entry_q [DEPTH];
   logic [W-1:0]  entry_d [DEPTH];

   always_comb begin
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      entry_d = entry_q;
      if (push_i && pop_i) begin
         // Net depth unchanged: replace the top entry.
         entry_d[ptr_q - PW'(1)] = link_i;
      end else if (push_i) begin
         entry_d[ptr_q] = link_i;
         ptr_d = ptr_q + PW'(1);
         if (cnt_q != FULL)
            cnt_d = cnt_q + (PW+1)'(1);
      end else if (pop_i && cnt_q != '0) begin
         ptr_d = ptr_q - PW'(1);
         cnt_d = cnt_q - (PW+1)'(1);
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge Clock) begin
      entry_q <= entry_d;
   end

   assign top_o   = entry_q[ptr_q - PW'(1)];
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: PC register, imem request,
// redirect arbitration and jr $ra prediction.
module pc_gen
   import cpu_pkg::*;
#(
   parameter int          ADDR_W    = 32,
   parameter logic [31:0] INIT_ADDR = PC_INIT_ADDR,
   parameter logic [31:0] EXC_ADDR  = PC_EXC_ADDR,
   parameter int          RAS_DEPTH = 4
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              stall_i,
   input  logic              exc_i,
   input  logic              br_taken_i,
   input  logic [ADDR_W-1:0] br_target_i,
   input  logic              jump_i,
   input  logic [25:0]       jump_index_i,
   input  logic [ADDR_W-1:0] jump_base_i,
   input  logic              call_i,
   input  logic [ADDR_W-1:0] link_i,
   input  logic              ret_i,
   input  logic              fetch_ready_i,
   output logic              fetch_valid_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              flush_o,
   output logic              align_err_o,
   output logic              ras_empty_o
);

   localparam logic [ADDR_W-1:0] INIT_PC = INIT_ADDR[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] EXC_PC  = EXC_ADDR[ADDR_W-1:0];

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              align_err_q, align_err_d;

   logic              run;
   logic              squash;
   logic              redir;
   logic              misal;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] tgt;
   logic [ADDR_W-1:0] jump_tgt;
   logic [ADDR_W-1:0] ras_top;
   logic              ras_empty;
   logic              unused_base;

   assign unused_base = ^jump_base_i[27:0];
   assign jump_tgt = {jump_base_i[ADDR_W-1:28], jump_index_i, 2'b00};

   pc_ras #(
      .DEPTH (RAS_DEPTH),
      .W     (ADDR_W)
   ) u_ras (
      .Clock   (Clock),
      .Reset   (Reset),
      .push_i  (push),
      .pop_i   (pop),
      .link_i  (link_i),
      .top_o   (ras_top),
      .empty_o (ras_empty)
   );

   always_comb begin
      run         = (state_q == ST_RUN);
      squash      = exc_i || br_taken_i;
      state_d     = ST_RUN;
      redir       = 1'b0;
      tgt         = pc_q;
      push        = run && call_i && !squash;
      pop         = 1'b0;
      if (run) begin
         if (exc_i) begin
            redir = 1'b1;
            tgt   = EXC_PC;
         end else if (br_taken_i) begin
            redir = 1'b1;
            tgt   = br_target_i;
         end else if (jump_i) begin
            redir = 1'b1;
            tgt   = jump_tgt;
         end else if (ret_i && !ras_empty) begin
            redir = 1'b1;
            tgt   = ras_top;
            pop   = 1'b1;
         end
      end
      misal       = redir && !exc_i && (tgt[1:0] != 2'b00);
      align_err_d = misal;
      if (misal)
         pc_d = EXC_PC;
      else if (redir)
         pc_d = tgt;
      else if (stall_i)
         pc_d = pc_q;
      else if (run && fetch_ready_i)
         pc_d = pc_q + ADDR_W'(PC_STEP);
      else
         pc_d = pc_q;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q     <= ST_BOOT;
         pc_q        <= INIT_PC;
         align_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         align_err_q <= align_err_d;
      end
   end

   assign fetch_valid_o = run;
   assign pc_o          = pc_q;
   assign flush_o       = redir;
   assign align_err_o   = align_err_q;
   assign ras_empty_o   = ras_empty;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen.
module tb_pc_gen;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        stall_i, exc_i, br_taken_i;
   logic [31:0] br_target_i;
   logic        jump_i;
   logic [25:0] jump_index_i;
   logic [31:0] jump_base_i;
   logic        call_i;
   logic [31:0] link_i;
   logic        ret_i;
   logic        fetch_ready_i;
   logic        fetch_valid_o;
   logic [31:0] pc_o;
   logic        flush_o, align_err_o, ras_empty_o;

   int checks = 0;
   int errors = 0;

   pc_gen dut (
      .Clock         (Clock),
      .Reset         (Reset),
      .stall_i       (stall_i),
      .exc_i         (exc_i),
      .br_taken_i    (br_taken_i),
      .br_target_i   (br_target_i),
      .jump_i        (jump_i),
      .jump_index_i  (jump_index_i),
      .jump_base_i   (jump_base_i),
      .call_i        (call_i),
      .link_i        (link_i),
      .ret_i         (ret_i),
      .fetch_ready_i (fetch_ready_i),
      .fetch_valid_o (fetch_valid_o),
      .pc_o          (pc_o),
      .flush_o       (flush_o),
      .align_err_o   (align_err_o),
      .ras_empty_o   (ras_empty_o)
   );

   always #5 Clock = ~Clock;

   task automatic step;
      @(posedge Clock);
      @(negedge Clock);
   endtask

   task automatic idle;
      stall_i = 0; exc_i = 0; br_taken_i = 0;
      jump_i = 0; call_i = 0; ret_i = 0;
   endtask

   task automatic test_reset;
      Reset = 1; fetch_ready_i = 1;
      br_target_i = 0; jump_index_i = 0;
      jump_base_i = 0; link_i = 0;
      idle();
      #12;
      checks++;
      if (pc_o !== 32'h3000) begin
         errors++; $display("FAIL reset_pc got %h exp 3000", pc_o);
      end
      checks++;
      if ({fetch_valid_o, flush_o, align_err_o, ras_empty_o} !== 4'b0001) begin
         errors++;
         $display("FAIL reset_flags got %b%b%b%b exp 0001",
            fetch_valid_o, flush_o, align_err_o, ras_empty_o);
      end
      @(negedge Clock);
      Reset = 0;
      #1;
      checks++;
      if (pc_o !== 32'h3000 || fetch_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL boot got %h v%b exp 3000 v0", pc_o, fetch_valid_o);
      end
      @(negedge Clock);
      checks++;
      if (pc_o !== 32'h3000 || fetch_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL run0 got %h v%b exp 3000 v1", pc_o, fetch_valid_o);
      end
      step();
      checks++;
      if (pc_o !== 32'h3004) begin
         errors++; $display("FAIL seq1 got %h exp 3004", pc_o);
      end
      step();
      checks++;
      if (pc_o !== 32'h3008) begin
         errors++; $display("FAIL seq2 got %h exp 3008", pc_o);
      end
   endtask

   task automatic test_stall;
      step(); step();
      checks++;
      if (pc_o !== 32'h3010) begin
         errors++; $display("FAIL pre_stall got %h exp 3010", pc_o);
      end
      stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (pc_o !== 32'h3010) begin
            errors++; $display("FAIL stall%0d got %h exp 3010", i, pc_o);
         end
      end
      stall_i = 0;
      step();
      checks++;
      if (pc_o !== 32'h3014) begin
         errors++; $display("FAIL post_stall got %h exp 3014", pc_o);
      end
   endtask

   task automatic test_redirect;
      exc_i = 1; br_taken_i = 1; br_target_i = 32'h3100;
      jump_i = 1; jump_index_i = 26'h0000C40; jump_base_i = 32'h3020;
      #1;
      checks++;
      if (flush_o !== 1'b1) begin
         errors++; $display("FAIL exc_flush got %b exp 1", flush_o);
      end
      step();
      idle();
      checks++;
      if (pc_o !== 32'h4180 || align_err_o !== 1'b0) begin
         errors++;
         $display("FAIL exc_pc got %h e%b exp 4180 e0", pc_o, align_err_o);
      end
      br_taken_i = 1; br_target_i = 32'h3102;
      #1;
      checks++;
      if (flush_o !== 1'b1) begin
         errors++; $display("FAIL mis_flush got %b exp 1", flush_o);
      end
      step();
      idle();
      checks++;
      if (pc_o !== 32'h4180 || align_err_o !== 1'b1) begin
         errors++;
         $display("FAIL mis_pc got %h e%b exp 4180 e1", pc_o, align_err_o);
      end
      step();
      checks++;
      if (pc_o !== 32'h4184 || align_err_o !== 1'b0) begin
         errors++;
         $display("FAIL mis_pulse got %h e%b exp 4184 e0", pc_o, align_err_o);
      end
   endtask

   task automatic test_jump;
      jump_i = 1; jump_index_i = 26'h0000C40; jump_base_i = 32'h3020;
      step();
      idle();
      checks++;
      if (pc_o !== 32'h3100) begin
         errors++; $display("FAIL jump got %h exp 3100", pc_o);
      end
      stall_i = 1; jump_i = 1; jump_index_i = 26'h0000C80;
      #1;
      checks++;
      if (flush_o !== 1'b1) begin
         errors++; $display("FAIL jstall_flush got %b exp 1", flush_o);
      end
      step();
      idle();
      checks++;
      if (pc_o !== 32'h3200) begin
         errors++; $display("FAIL jump_stall got %h exp 3200", pc_o);
      end
   endtask

   task automatic test_ras;
      logic [31:0] exp_pop [4];
      exp_pop = '{32'h50, 32'h40, 32'h30, 32'h20};
      for (int i = 1; i <= 5; i++) begin
         call_i = 1; link_i = 32'(i * 16);
         step();
      end
      idle();
      checks++;
      if (ras_empty_o !== 1'b0 || pc_o !== 32'h3214) begin
         errors++;
         $display("FAIL push got %h e%b exp 3214 e0", pc_o, ras_empty_o);
      end
      for (int i = 0; i < 4; i++) begin
         ret_i = 1;
         step();
         checks++;
         if (pc_o !== exp_pop[i]) begin
            errors++;
            $display("FAIL pop%0d got %h exp %h", i, pc_o, exp_pop[i]);
         end
      end
      checks++;
      if (ras_empty_o !== 1'b1) begin
         errors++; $display("FAIL ras_empty got %b exp 1", ras_empty_o);
      end
      #1;
      checks++;
      if (flush_o !== 1'b0) begin
         errors++; $display("FAIL pop_empty_flush got %b exp 0", flush_o);
      end
      step();
      idle();
      checks++;
      if (pc_o !== 32'h24) begin
         errors++; $display("FAIL pop_empty got %h exp 24", pc_o);
      end
   endtask

   task automatic test_squash;
      call_i = 1; link_i = 32'h60;
      step();
      idle();
      ret_i = 1; br_taken_i = 1; br_target_i = 32'h3300;
      step();
      idle();
      checks++;
      if (pc_o !== 32'h3300 || ras_empty_o !== 1'b0) begin
         errors++;
         $display("FAIL ret_br got %h e%b exp 3300 e0", pc_o, ras_empty_o);
      end
      call_i = 1; link_i = 32'h70; jump_i = 1;
      jump_index_i = 26'h0000D00; jump_base_i = 32'h3304;
      step();
      idle();
      checks++;
      if (pc_o !== 32'h3400) begin
         errors++; $display("FAIL call_jump got %h exp 3400", pc_o);
      end
      ret_i = 1; jump_i = 1; jump_index_i = 26'h0000D40;
      step();
      idle();
      checks++;
      if (pc_o !== 32'h3500) begin
         errors++; $display("FAIL ret_jump got %h exp 3500", pc_o);
      end
      ret_i = 1;
      step();
      checks++;
      if (pc_o !== 32'h70) begin
         errors++; $display("FAIL ret_a got %h exp 70", pc_o);
      end
      step();
      idle();
      checks++;
      if (pc_o !== 32'h60 || ras_empty_o !== 1'b1) begin
         errors++;
         $display("FAIL ret_b got %h e%b exp 60 e1", pc_o, ras_empty_o);
      end
   endtask

   task automatic test_mid_reset;
      call_i = 1; link_i = 32'h80;
      step();
      idle();
      #2;
      Reset = 1;
      #1;
      checks++;
      if (pc_o !== 32'h3000 || fetch_valid_o !== 1'b0 || ras_empty_o !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset got %h v%b e%b exp 3000 v0 e1",
            pc_o, fetch_valid_o, ras_empty_o);
      end
      @(negedge Clock);
      Reset = 0;
      step();
      step();
      checks++;
      if (pc_o !== 32'h3004 || fetch_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL after_reset got %h v%b exp 3004 v1", pc_o, fetch_valid_o);
      end
   endtask

   initial begin
      test_reset();
      test_stall();
      test_redirect();
      test_jump();
      test_ras();
      test_squash();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
